// File: rtl/data_memory_arbiter.sv
// data_memory_arbiter: two-port arbiter and access sequencer in front of the
// single-port data_memory. Port 0 is the core load/store unit, port 1 is the
// debug/DMA port. One memory access is in flight at a time.
// Optional feature: define DATA_MEM_ARB_RR_EN for round-robin tie breaking;
// otherwise port 0 wins ties (fixed priority).
module data_memory_arbiter #(
   parameter int W = 32,
   parameter int N = 5
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         p0_req,
   input  logic         p0_we,
   input  logic [N-1:0] p0_addr,
   input  logic [W-1:0] p0_wdata,
   input  logic         p1_req,
   input  logic         p1_we,
   input  logic [N-1:0] p1_addr,
   input  logic [W-1:0] p1_wdata,
   output logic         p0_gnt,
   output logic         p1_gnt,
   output logic         p0_done,
   output logic         p1_done,
   output logic [W-1:0] rdata,
   output logic         busy,
   output logic [N-1:0] address,
   output logic [W-1:0] write_data,
   output logic         MemWrite,
   output logic         MemRead,
   input  logic [W-1:0] read_data
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ISSUE  = 2'd1,
      RDWAIT = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t state;
   logic   lat_we;
   logic   win;
   logic   sel;

`ifdef DATA_MEM_ARB_RR_EN
   // Index of the most recently granted port; a tie goes to the other one.
   logic   last_port;
`endif

   // Pick the winning port from the current requests.
   always_comb begin
      sel = 1'b0;
      if (p1_req && !p0_req) begin
         sel = 1'b1;
      end else if (p0_req && p1_req) begin
`ifdef DATA_MEM_ARB_RR_EN
         sel = ~last_port;
`else
         sel = 1'b0;
`endif
      end
   end

   // Memory strobes last exactly the ISSUE cycle and are suppressed while
   // reset is asserted, so a write caught by reset is never committed.
   assign MemWrite = rst & (state == ISSUE) &  lat_we;
   assign MemRead  = rst & (state == ISSUE) & ~lat_we;

   // Sequencer: latch the winning command, issue it, collect read data, signal completion.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= IDLE;
         lat_we     <= 1'b0;
         win        <= 1'b0;
         address    <= '0;
         write_data <= '0;
         rdata      <= '0;
         busy       <= 1'b0;
         p0_gnt     <= 1'b0;
         p1_gnt     <= 1'b0;
         p0_done    <= 1'b0;
         p1_done    <= 1'b0;
`ifdef DATA_MEM_ARB_RR_EN
         last_port  <= 1'b1;
`endif
      end else begin
         p0_gnt  <= 1'b0;
         p1_gnt  <= 1'b0;
         p0_done <= 1'b0;
         p1_done <= 1'b0;
         case (state)
            IDLE: begin
               if (p0_req || p1_req) begin
                  win        <= sel;
                  lat_we     <= sel ? p1_we    : p0_we;
                  address    <= sel ? p1_addr  : p0_addr;
                  write_data <= sel ? p1_wdata : p0_wdata;
                  p0_gnt     <= ~sel;
                  p1_gnt     <= sel;
                  busy       <= 1'b1;
                  state      <= ISSUE;
`ifdef DATA_MEM_ARB_RR_EN
                  last_port  <= sel;
`endif
               end
            end
            ISSUE: begin
               if (lat_we) begin
                  p0_done <= ~win;
                  p1_done <= win;
                  state   <= DONE;
               end else begin
                  state   <= RDWAIT;
               end
            end
            RDWAIT: begin
               rdata   <= read_data;
               p0_done <= ~win;
               p1_done <= win;
               state   <= DONE;
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/data_memory_arbiter.md
# data_memory_arbiter

Two-port arbiter and access sequencer in front of the single-port `data_memory` (W=32, N=5). It accepts load/store requests from two requesters: port 0, the core load/store unit, and port 1, the debug/DMA port. It selects one request and drives the memory's `address`/`MemWrite`/`MemRead`/`write_data`, then captures `read_data` and returns it with a completion pulse. Only one memory access is in flight at a time.

## Interface
- `W`, 32, data width; must match `data_memory`.
- `N`, 5, address width; must match `data_memory`.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `p0_req`, `p1_req`  in  1  request; sampled only in IDLE.
- `p0_we`, `p1_we`  in  1  1 = write, 0 = read.
- `p0_addr`, `p1_addr`  in  N  word address.
- `p0_wdata`, `p1_wdata`  in  W  store data.
- `p0_gnt`, `p1_gnt`  out  1  one-cycle pulse: request accepted.
- `p0_done`, `p1_done`  out  1  one-cycle pulse: access complete.
- `rdata`  out  W  load data; valid when `pX_done` is high for a read; held until the next read completes.
- `busy`  out  1  high in every state except IDLE.
- `address`  out  N  to `data_memory`.
- `write_data`  out  W  to `data_memory`.
- `MemWrite`, `MemRead`  out  1  to `data_memory`.
- `read_data`  in  W  from `data_memory`; registered there, valid the cycle after `MemRead`.

## Operation
- **FSM states:** IDLE, ISSUE, RDWAIT, DONE.
- **IDLE:**
  - If any `req` is high, select the winner and latch its `we`/`addr`/`wdata` into internal registers.
  - Record the winner index and go to ISSUE.
  - If no `req` is high, stay in IDLE.
- **ISSUE:**
  - Drive `address`/`write_data` from the latched registers and assert exactly one of `MemWrite`/`MemRead` for one cycle.
  - Next state: RDWAIT if the access is a read, DONE if it is a write.
- **RDWAIT:** load the `rdata` register from `read_data`, then go to DONE.
- **DONE:** `pX_done` of the winner is high, then go to IDLE.
- **Grant:** `pX_gnt` of the winner is high during ISSUE; `gnt` and `done` are never both high.
- **Request ownership:**
  - `req` and its command fields are sampled only at the IDLE edge.
  - `req` seen in ISSUE, RDWAIT or DONE is ignored.
  - A `req` still high on return to IDLE starts a new transaction; a requester must drop `req` after `gnt` to avoid a repeat.
- **Arbitration:** a single requester always wins. On a tie, the winner is set by the Configuration macro.
- **Memory outputs outside ISSUE:** `address` and `write_data` hold the last latched values; `MemWrite` = `MemRead` = 0.
- **Reset gating:** `MemWrite` and `MemRead` are decoded from state and ANDed with `rst`. No memory strobe is issued in any cycle where `rst` is low.

## Timing
- **Reset values** (1 edge with `rst` = 0):
  - State IDLE.
  - All `gnt`/`done`/`busy`/`MemWrite`/`MemRead` = 0.
  - `address` = 0, `write_data` = 0, `rdata` = 0.
  - Round-robin pointer set to "port 1 last".
- **Cycle numbering:** cycle 0 is the cycle in which `req` is high while in IDLE.
- **Write:** ISSUE in cycle 1 (`gnt`, `MemWrite`); the memory commits at the end of cycle 1; `done` in cycle 2. Issue interval: 3 cycles.
- **Read:** ISSUE in cycle 1 (`gnt`, `MemRead`); RDWAIT in cycle 2 (`read_data` valid and captured); `done` + `rdata` in cycle 3. Issue interval: 4 cycles.
- **Back-to-back:** IDLE lasts at least 1 cycle between transactions.
- **Reset mid-operation:** `rst` low in any state returns the block to IDLE at that edge.
  - The pending `done` is lost.
  - A write whose ISSUE cycle has `rst` low is not committed.
- **Address range:** any N-bit address is legal; there is no wrap or bounds check.

## Configuration
- **`DATA_MEM_ARB_RR_EN` defined:** round-robin.
  - On a tie, grant the port not granted most recently.
  - The pointer updates on every grant.
  - After reset, port 0 wins the first tie.
- **`DATA_MEM_ARB_RR_EN` undefined:** fixed priority; port 0 always wins ties and the pointer logic is absent.

## Test plan
- **Reset:** hold `rst` = 0 for 2 cycles with both `req` high → all outputs 0, no `MemWrite`/`MemRead`, `busy` = 0.
- **Single write then read:** p0 writes `0xDEADBEEF` to addr 5, then reads addr 5.
  - Write: `MemWrite` in cycle 1, `p0_done` in cycle 2.
  - Read: `p0_done` in cycle 3 with `rdata` = `0xDEADBEEF`.
- **Sweep:** p1 writes `$random` to all 32 addresses, then reads each back → `rdata` matches `dut.mem[i]`.
- **Contention:** both `req` held high, reads to addrs 1 and 2.
  - With RR_EN: grants alternate p0, p1, p0, p1.
  - Without RR_EN: p0 only while its `req` stays high.
- **Reset mid-write:** drop `rst` during the ISSUE cycle of a write of `0x12345678` to addr 3 → `mem[3]` unchanged, no `done`, state IDLE.
- **Held req:** p0 keeps `req` high through DONE → a second transaction starts with `gnt` 2 cycles after the first `done`.
